// File: rtl/lc3_mem_interface.sv
// LC-3 memory-side stage: owns MAR/MDR and runs a req/ack handshake to a
// variable-latency memory, holding the controller off via memReady.
module lc3_mem_interface #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  ldMAR,
  input  logic                  ldMDR,
  input  logic                  selMDR,
  input  logic                  memWE,
  input  logic                  enaMDR,
  output logic [DATA_WIDTH-1:0] mdrOut,
  output logic                  mdrDrive,
  output logic                  memReady,
  output logic                  memReq,
  output logic                  memWr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic [DATA_WIDTH-1:0] memRData,
  input  logic                  memAck,
  output logic                  memErr
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_err_q, mem_err_d;

  logic start_rd, start_wr, last_wait;

  // A write request always beats a simultaneous memory read request.
  assign start_wr  = memWE;
  assign start_rd  = ldMDR & selMDR & ~memWE;
  assign last_wait = (wait_cnt_q == LAST_WAIT);

  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    wait_cnt_d = wait_cnt_q;
    mem_req_d  = mem_req_q;
    mem_wr_d   = mem_wr_q;
    mem_err_d  = mem_err_q;
    memReady   = 1'b1;

    unique case (state_q)
      IDLE: begin
        memReady = ~(start_rd | start_wr);
        // Loads land in the same edge as the start, so the access sees them.
        if (ldMAR) mar_d = ADDR_WIDTH'(bus);
        if (ldMDR && !selMDR) mdr_d = bus;
        if (start_wr) begin
          state_d    = WRITE_WAIT;
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b1;
          wait_cnt_d = '0;
        end else if (start_rd) begin
          state_d    = READ_WAIT;
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          wait_cnt_d = '0;
        end
      end

      READ_WAIT, WRITE_WAIT: begin
        memReady = memAck | last_wait;
        if (memAck) begin
          if (state_q == READ_WAIT) mdr_d = memRData;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (last_wait) begin
          // Timeout: give up, flag it, leave MDR untouched.
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      mar_q      <= '0;
      mdr_q      <= '0;
      wait_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      wait_cnt_q <= wait_cnt_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mdrOut   = mdr_q;
  assign mdrDrive = enaMDR;
  assign memReq   = mem_req_q;
  assign memWr    = mem_wr_q;
  assign memAddr  = mar_q;
  assign memWData = mdr_q;
  assign memErr   = mem_err_q;

endmodule

// File: doc/lc3_mem_interface.md
Name: lc3_mem_interface

Overview:
- Memory-side stage directly downstream of the LC-3 multicycle controller.
- Owns the MAR and MDR registers and performs the memory accesses the controller requests (ldMAR, ldMDR/selMDR, memWE, enaMDR).
- Runs a req/ack handshake to a variable-latency external memory.
- Returns memReady so the controller holds its current state until an access completes.

Parameters:
- ADDR_WIDTH, 16, MAR / memAddr width.
- DATA_WIDTH, 16, MDR / bus / memory data width.
- MAX_WAIT, 255, wait-state cycles without memAck before an access is aborted (1..2^16-1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising clk edge while reset=0.
- bus  in  DATA_WIDTH  processor bus value (MAR/MDR load source).
- ldMAR  in  1  load MAR from bus.
- ldMDR  in  1  load MDR.
- selMDR  in  1  MDR source: 1=memory read, 0=bus.
- memWE  in  1  write MDR to mem[MAR].
- enaMDR  in  1  request to drive MDR onto bus.
- mdrOut  out  DATA_WIDTH  current MDR value.
- mdrDrive  out  1  equals enaMDR; the datapath bus mux uses it.
- memReady  out  1  controller may advance at the next edge.
- memReq  out  1  external access request (registered).
- memWr  out  1  1=write, 0=read; valid while memReq=1.
- memAddr  out  ADDR_WIDTH  equals MAR.
- memWData  out  DATA_WIDTH  equals MDR.
- memRData  in  DATA_WIDTH  read data; sampled when memAck=1.
- memAck  in  1  external completion, one-cycle pulse.
- memErr  out  1  sticky timeout flag.

Behaviour:
- Reset values: MAR=0, MDR=0, state=IDLE, waitCnt=0, memReq=0, memWr=0, memErr=0.
  - memReady=1 out of reset, since IDLE has no op pending.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- Definitions: startRd = ldMDR & selMDR & ~memWE; startWr = memWE.
- IDLE:
  - ldMAR: MAR<=bus.
  - ldMDR & ~selMDR: MDR<=bus.
  - startWr: next state WRITE_WAIT; memReq<=1, memWr<=1.
  - startRd (no startWr): next state READ_WAIT; memReq<=1, memWr<=0.
  - waitCnt<=0 on entry to either wait state.
  - memReady = ~(startRd | startWr), combinational.
- Simultaneous loads with a start in IDLE:
  - ldMAR together with a start: the access uses the newly loaded MAR.
  - ldMDR(bus) together with memWE: the write uses the newly loaded MDR.
  - memWE together with ldMDR & selMDR: write wins; the read is dropped.
- READ_WAIT / WRITE_WAIT:
  - MAR and MDR are frozen; ldMAR, ldMDR, memWE are ignored.
  - The controller holds its command until memReady=1.
  - memReady = memAck | (waitCnt==MAX_WAIT-1), combinational.
  - On memAck: READ_WAIT sets MDR<=memRData. Both states then set memReq<=0 and go to IDLE.
  - Minimum access is 2 cycles (ack in the first wait cycle).
- Timeout:
  - No ack and waitCnt==MAX_WAIT-1: memErr<=1, memReq<=0, go to IDLE.
  - MDR is unchanged.
  - Counter saturates; it does not wrap.
- Ack outside a wait state: memAck in IDLE (late or spurious) is ignored; MDR is unchanged.
- memErr: clears only on reset and does not block later accesses.
- Reset mid-access: memReq=0 after the reset edge; pending data is discarded.

Test Plan:
- Reset: hold reset=0 for 2 cycles with memAck=1 → memReq=0, MAR=0, MDR=0, memErr=0, memReady=1.
- Read, 3-cycle latency:
  - Stimulus: bus=0x3000 with ldMAR; mem[0x3000]=0xBEEF; then ldMDR=selMDR=1; memAck 3 cycles after memReq rises.
  - Response: memAddr=0x3000, memWr=0, memReady=0 until the ack cycle, MDR=0xBEEF after that edge, back to IDLE.
- Write with simultaneous MDR load:
  - Stimulus: MAR=0x4001; bus=0x1234 with ldMDR=1, selMDR=0, memWE=1 in one cycle; ack after 1 cycle.
  - Response: memWr=1, memWData=0x1234, one write seen at 0x4001.
- Timeout: MAX_WAIT=4, read with no ack → memReady=1 on the 4th wait cycle, memErr=1 stays set, MDR unchanged; a following read with ack completes normally.
- Command conflicts:
  - memWE and ldMDR & selMDR together → only a write is issued.
  - ldMAR=0xFFFF during READ_WAIT → MAR unchanged.
  - Late memAck in IDLE → MDR unchanged.
- Reset mid-read: reset=0 in the 2nd wait cycle → memReq=0 next cycle, IDLE, MDR=0; a subsequent memAck is ignored.
